gcd_serial_param: RTL and testbench

- Parametrised successor to the fixed 8-bit, 2-beat serial GCD block.
- Operands of OP_W = BUS_W*BEATS bits arrive over a narrow BUS_W-wide bus, MSB beat first.
- Computes the greatest common divisor with a one-step-per-cycle binary (Stein) algorithm.
- Streams the result back MSB beat first.
- Adds BUSY, defined zero-operand error handling, and an optional iteration counter.

---
 rtl/gcd_serial_param.sv | 164 ++++++++++++++++
 tb/tb_gcd_serial_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gcd_serial_param.sv
// Serial binary (Stein) GCD: operands arrive BEATS x BUS_W MSB-first, result streams back the same way.
// Optional iteration counter output ITER is compiled in with `define GCD_ITER_CNT_EN.
module gcd_serial_param #(
  parameter int BUS_W  = 8,
  parameter int BEATS  = 2,
  parameter int ITER_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [BUS_W-1:0] A,
  input  logic [BUS_W-1:0] B,
  output logic [BUS_W-1:0] Y,
  output logic             DONE,
  output logic             ERROR,
  output logic             BUSY
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [ITER_W-1:0] ITER
`endif
);

  localparam int OP_W = BUS_W * BEATS;
  localparam int K_W  = $clog2(OP_W) + 1;
  localparam int BC_W = $clog2(BEATS + 1);
  localparam logic [BC_W-1:0] LAST_LD  = BC_W'((BEATS > 1) ? BEATS - 2 : 0);
  localparam logic [BC_W-1:0] LAST_OUT = BC_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t            state, nstate;
  logic [OP_W-1:0]   rega, regb, res;
  logic [K_W-1:0]    k;
  logic [BC_W-1:0]   bcnt;
  logic              err;

  logic [OP_W-1:0]   a_base, b_base, a_in, b_in;
  logic              load_fin, zero_op, eq;

  // The first beat shifts into a cleared register, so after BEATS shifts it sits on top.
  assign a_base = (state == S_IDLE) ? '0 : rega;
  assign b_base = (state == S_IDLE) ? '0 : regb;

  generate
    if (BEATS == 1) begin : g_one_beat
      assign a_in = A;
      assign b_in = B;
    end else begin : g_multi_beat
      assign a_in = {a_base[OP_W-BUS_W-1:0], A};
      assign b_in = {b_base[OP_W-BUS_W-1:0], B};
    end
  endgenerate

  assign load_fin = (BEATS == 1) ? (state == S_IDLE && START)
                                 : (state == S_LOAD && bcnt == LAST_LD);
  assign zero_op  = (a_in == '0) || (b_in == '0);
  assign eq       = (rega == regb);

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    DONE   = 1'b0;
    ERROR  = 1'b0;
    BUSY   = 1'b1;
    Y      = '0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          if (BEATS == 1) nstate = zero_op ? S_OUT : S_CALC;
          else            nstate = S_LOAD;
        end
      end
      S_LOAD: if (load_fin) nstate = zero_op ? S_OUT : S_CALC;
      S_CALC: if (eq) nstate = S_OUT;
      S_OUT: begin
        DONE  = 1'b1;
        ERROR = err;
        Y     = res[OP_W-1 -: BUS_W];
        if (bcnt == LAST_OUT) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rega <= '0;
      regb <= '0;
      res  <= '0;
      k    <= '0;
      bcnt <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bcnt <= '0;
          if (START) begin
            rega <= a_in;
            regb <= b_in;
            k    <= '0;
            res  <= '0;
            err  <= load_fin & zero_op;
          end
        end
        S_LOAD: begin
          rega <= a_in;
          regb <= b_in;
          bcnt <= load_fin ? '0 : bcnt + 1'b1;
          if (load_fin) err <= zero_op;
        end
        S_CALC: begin
          // Stein step; odd-odd subtraction always takes larger minus smaller
          if (eq) begin
            res  <= rega << k;
            bcnt <= '0;
          end else if (!rega[0] && !regb[0]) begin
            rega <= rega >> 1;
            regb <= regb >> 1;
            k    <= k + 1'b1;
          end else if (!rega[0]) begin
            rega <= rega >> 1;
          end else if (!regb[0]) begin
            regb <= regb >> 1;
          end else if (rega > regb) begin
            rega <= rega - regb;
          end else begin
            regb <= regb - rega;
          end
        end
        S_OUT: begin
          res  <= res << BUS_W;
          bcnt <= bcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_ITER_CNT_EN
  logic [ITER_W-1:0] cnt, cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // cnt holds completed CALC steps; the terminating a==b step is counted on OUT entry
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt  <= '0;
      ITER <= '0;
    end else if (load_fin) begin
      cnt <= '0;
      if (zero_op) ITER <= '0;
    end else if (state == S_CALC) begin
      cnt <= cnt_inc;
      if (eq) ITER <= cnt_inc;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_serial_param.sv
// Directed bench for gcd_serial_param: default 8x2 instance plus a 4x3 instance.
module tb_gcd_serial_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0, y;
  logic       done, error, busy;

  logic       start_w = 1'b0;
  logic [3:0] a_w = '0, b_w = '0, y_w;
  logic       done_w, error_w, busy_w;

`ifdef GCD_ITER_CNT_EN
  logic [7:0] iter, iter_w;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gcd_serial_param #(.BUS_W(8), .BEATS(2), .ITER_W(8)) u_d (
    .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b),
    .Y(y), .DONE(done), .ERROR(error), .BUSY(busy)
`ifdef GCD_ITER_CNT_EN
    , .ITER(iter)
`endif
  );

  gcd_serial_param #(.BUS_W(4), .BEATS(3), .ITER_W(8)) u_w (
    .CLK(clk), .RST_N(rst_n), .START(start_w), .A(a_w), .B(b_w),
    .Y(y_w), .DONE(done_w), .ERROR(error_w), .BUSY(busy_w)
`ifdef GCD_ITER_CNT_EN
    , .ITER(iter_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Two-beat load, wait for DONE (counting CALC cycles), then check both result beats.
  // inj >= 0 pulses START with zero operands on that wait cycle.
  task automatic run_op(input string tag, input logic [7:0] ah, bh, al, bl,
                        input logic [7:0] yh, yl, input logic er,
                        input int lat, input int inj);
    int n;
    start = 1'b1; a = ah; b = bh;
    tick();
    chk({tag, ".busy_rise"}, 32'(busy), 1);
    start = 1'b0; a = al; b = bl;
    tick();
    n = 0;
    while (!done && n < 100) begin
      start = (n == inj);
      if (n == inj) begin a = 8'h00; b = 8'h00; end
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".done0"}, 32'(done), 1);
    chk({tag, ".y0"}, 32'(y), 32'(yh));
    chk({tag, ".err0"}, 32'(error), 32'(er));
    tick();
    chk({tag, ".done1"}, 32'(done), 1);
    chk({tag, ".y1"}, 32'(y), 32'(yl));
    chk({tag, ".err1"}, 32'(error), 32'(er));
    tick();
    chk({tag, ".done_fall"}, 32'(done), 0);
    chk({tag, ".y_idle"}, 32'(y), 0);
    chk({tag, ".err_fall"}, 32'(error), 0);
    chk({tag, ".busy_fall"}, 32'(busy), 0);
`ifdef GCD_ITER_CNT_EN
    chk({tag, ".iter"}, 32'(iter), er ? 0 : 32'(lat));
`endif
  endtask

  initial begin
    int nd;
    int n;
    tick();
    tick();
    chk("rst.y", 32'(y), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err", 32'(error), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.busy_w", 32'(busy_w), 0);
`ifdef GCD_ITER_CNT_EN
    chk("rst.iter", 32'(iter), 0);
`endif
    rst_n = 1'b1;
    tick();

    // 900,450 -> 450 ; CALC: both even, a even, equal
    run_op("g900_450", 8'd3, 8'd1, 8'd132, 8'd194, 8'd1, 8'd194, 1'b0, 3, -1);
    run_op("g450_900", 8'd1, 8'd3, 8'd194, 8'd132, 8'd1, 8'd194, 1'b0, 3, -1);
    // 3096,1428 -> 12 in 18 steps
    run_op("g3096_1428", 8'd12, 8'd5, 8'd24, 8'd148, 8'd0, 8'd12, 1'b0, 18, -1);
    run_op("zero_zero", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 0, -1);
    run_op("zero_259", 8'd0, 8'd1, 8'd0, 8'd3, 8'd0, 8'd0, 1'b1, 0, -1);
    run_op("one_one", 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 1'b0, 1, -1);
    run_op("all_ones", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1, -1);

    // reset mid-CALC discards the operation
    start = 1'b1; a = 8'd12; b = 8'd5;
    tick();
    start = 1'b0; a = 8'd24; b = 8'd148;
    tick();
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.y", 32'(y), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.err", 32'(error), 0);
    chk("midrst.busy", 32'(busy), 0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done) nd++;
    end
    chk("midrst.no_done", 32'(nd), 0);
    run_op("post_rst", 8'd3, 8'd1, 8'd132, 8'd194, 8'd1, 8'd194, 1'b0, 3, -1);

    // START with zero operands during CALC must not disturb the running operation
    run_op("start_in_calc", 8'd12, 8'd5, 8'd24, 8'd148, 8'd0, 8'd12, 1'b0, 18, 2);

    // 4-bit x 3-beat instance: 0x0FF,0x0FF -> 0x0FF
    start_w = 1'b1; a_w = 4'h0; b_w = 4'h0;
    tick();
    start_w = 1'b0; a_w = 4'hF; b_w = 4'hF;
    tick();
    tick();
    n = 0;
    while (!done_w && n < 100) begin
      tick();
      n++;
    end
    chk("w.lat", 32'(n), 1);
    chk("w.y0", 32'(y_w), 32'h0);
    tick();
    chk("w.y1", 32'(y_w), 32'hF);
    tick();
    chk("w.y2", 32'(y_w), 32'hF);
    chk("w.err", 32'(error_w), 0);
    tick();
    chk("w.done_fall", 32'(done_w), 0);
    chk("w.busy_fall", 32'(busy_w), 0);
`ifdef GCD_ITER_CNT_EN
    chk("w.iter", 32'(iter_w), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
